// File: rtl/exu_sched.sv
// Execute-stage sequencer: routes single-cycle ops to the shared ALU and runs
// DIV/REM (incl. W forms) on an iterative radix-2 restoring divider.
module exu_sched #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned ALU_OP_W = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] in_alu_op,
    input  logic [3:0]          in_div_op,
    input  logic                in_32,
    input  logic [XLEN-1:0]     in_src1,
    input  logic [XLEN-1:0]     in_src2,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [XLEN-1:0]     alu_src1,
    output logic [XLEN-1:0]     alu_src2,
    output logic                alu_32,
    input  logic [XLEN-1:0]     alu_result,
    input  logic                alu_over,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_result,
    output logic                out_err,
    output logic                busy
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_HOLD} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] res_q, res_n;
    logic            err_q, err_n;
    logic [XLEN-1:0] rem_q, rem_n, quot_q, quot_n, dvsr_q, dvsr_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            qneg_q, qneg_n, rneg_q, rneg_n;
    logic            isrem_q, isrem_n, w_q, w_n;

    logic            accept, signed_op, rem_op, s1, s2, ovf;
    logic [XLEN-1:0] opa, opb, mag_a, mag_b, min_neg;
    logic [XLEN:0]   shifted, diff;
    logic            ge;
    logic [XLEN-1:0] qv, rv, sel;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    assign in_ready   = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign out_valid  = (state == S_HOLD);
    assign out_result = res_q;
    assign out_err    = err_q;
    assign alu_op     = (in_valid && state == S_IDLE && in_div_op == '0) ? in_alu_op : '0;
    assign alu_src1   = in_src1;
    assign alu_src2   = in_src2;
    assign alu_32     = in_32;

    assign accept    = in_valid && (state == S_IDLE) && !flush;
    assign signed_op = in_div_op[3] | in_div_op[1];
    assign rem_op    = in_div_op[1] | in_div_op[0];

    always_comb begin
        opa = in_src1;
        opb = in_src2;
        if (in_32) begin
            opa = signed_op ? sext32(in_src1) : {{(XLEN-32){1'b0}}, in_src1[31:0]};
            opb = signed_op ? sext32(in_src2) : {{(XLEN-32){1'b0}}, in_src2[31:0]};
        end
    end

    assign s1      = signed_op & opa[XLEN-1];
    assign s2      = signed_op & opb[XLEN-1];
    assign mag_a   = s1 ? -opa : opa;
    assign mag_b   = s2 ? -opb : opb;
    assign min_neg = in_32 ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    assign ovf     = signed_op && (opa == min_neg) && (opb == '1);

    // Partial remainder can reach 2*divisor-1, so the trial subtract needs XLEN+1 bits.
    assign shifted = {rem_q, quot_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvsr_q};
    assign ge      = ~diff[XLEN];

    assign qv  = qneg_q ? -quot_q : quot_q;
    assign rv  = rneg_q ? -rem_q : rem_q;
    assign sel = isrem_q ? rv : qv;

    always_comb begin
        state_n = state;
        res_n   = res_q;
        err_n   = err_q;
        rem_n   = rem_q;
        quot_n  = quot_q;
        dvsr_n  = dvsr_q;
        cnt_n   = cnt_q;
        qneg_n  = qneg_q;
        rneg_n  = rneg_q;
        isrem_n = isrem_q;
        w_n     = w_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_HOLD;
                    if (in_div_op == '0) begin
                        res_n = alu_result;
                        err_n = ~alu_over;
                    end else begin
                        err_n   = 1'b0;
                        isrem_n = rem_op;
                        w_n     = in_32;
                        qneg_n  = s1 ^ s2;
                        rneg_n  = s1;
                        if (opb == '0) begin
                            res_n = rem_op ? opa : '1;
                            if (in_32) res_n = sext32(res_n);
                        end else if (ovf) begin
                            res_n = rem_op ? '0 : opa;
                        end else begin
                            // W forms pre-align the dividend to the MSB so the same step logic runs 32 times.
                            rem_n   = '0;
                            quot_n  = in_32 ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
                            dvsr_n  = mag_b;
                            cnt_n   = in_32 ? CW'(31) : CW'(XLEN-1);
                            state_n = S_DIV;
                        end
                    end
                end
            end
            S_DIV: begin
                rem_n  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                quot_n = {quot_q[XLEN-2:0], ge};
                cnt_n  = cnt_q - 1'b1;
                if (cnt_q == '0) state_n = S_FIX;
            end
            S_FIX: begin
                res_n   = w_q ? sext32(sel) : sel;
                state_n = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (flush) state_n = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            res_q   <= '0;
            err_q   <= 1'b0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            isrem_q <= 1'b0;
            w_q     <= 1'b0;
        end else begin
            state   <= state_n;
            res_q   <= res_n;
            err_q   <= err_n;
            rem_q   <= rem_n;
            quot_q  <= quot_n;
            dvsr_q  <= dvsr_n;
            cnt_q   <= cnt_n;
            qneg_q  <= qneg_n;
            rneg_q  <= rneg_n;
            isrem_q <= isrem_n;
            w_q     <= w_n;
        end
    end
endmodule

// File: tb/tb_exu_sched.sv
// Directed bench for exu_sched with a small behavioural ALU on the ALU port.
module tb_exu_sched;
    localparam int unsigned XLEN = 64;
    localparam int unsigned AW   = 12;

    localparam logic [AW-1:0] OP_ADD = 12'h800;
    localparam logic [AW-1:0] OP_SLT = 12'h200;
    localparam logic [AW-1:0] OP_SP  = 12'h001;
    localparam logic [3:0] D_DIV  = 4'b1000;
    localparam logic [3:0] D_DIVU = 4'b0100;
    localparam logic [3:0] D_REM  = 4'b0010;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready, in_32;
    logic [AW-1:0]   in_alu_op, alu_op;
    logic [3:0]      in_div_op;
    logic [XLEN-1:0] in_src1, in_src2, alu_src1, alu_src2, alu_result, out_result;
    logic            alu_32, alu_over, out_valid, out_ready, out_err, busy;

    int tests = 0;
    int fails = 0;
    int lat;
    logic seen;

    exu_sched #(.XLEN(XLEN), .ALU_OP_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_div_op(in_div_op), .in_32(in_32),
        .in_src1(in_src1), .in_src2(in_src2),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_32(alu_32),
        .alu_result(alu_result), .alu_over(alu_over),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference ALU; op_sp is deliberately unrecognised and returns a marker value.
    always_comb begin
        alu_result = '0;
        alu_over   = 1'b1;
        case (alu_op)
            12'h800: alu_result = alu_src1 + alu_src2;
            12'h400: alu_result = alu_src1 - alu_src2;
            12'h200: alu_result = {63'b0, $signed(alu_src1) < $signed(alu_src2)};
            12'h100: alu_result = {63'b0, alu_src1 < alu_src2};
            12'h080: alu_result = alu_src1 & alu_src2;
            12'h040: alu_result = alu_src1 | alu_src2;
            12'h020: alu_result = alu_src1 ^ alu_src2;
            12'h001: begin alu_result = 64'hA5A5_5A5A_DEAD_BEEF; alu_over = 1'b0; end
            default: alu_over = (alu_op != '0);
        endcase
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [AW-1:0] aop, input logic [3:0] dop, input logic w,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        @(negedge clk);
        in_valid = 1'b1; in_alu_op = aop; in_div_op = dop; in_32 = w;
        in_src1 = a; in_src2 = b;
        @(negedge clk);
        in_valid = 1'b0; in_alu_op = '0; in_div_op = '0; in_32 = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int l);
        l = 1;
        while (!out_valid && l < budget) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic div_case(input string tag, input logic [3:0] dop, input logic w,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input int exp_lat, input logic [XLEN-1:0] exp_res);
        issue('0, dop, w, a, b);
        wait_valid(100, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, out_result, exp_res);
        @(negedge clk);
        chk({tag, "_done"}, {63'b0, out_valid}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_alu_op = '0; in_div_op = '0;
        in_32 = 1'b0; in_src1 = '0; in_src2 = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_err", {63'b0, out_err}, 64'd0);
        chk("rst_ready", {63'b0, in_ready}, 64'd1);
        rst_n = 1'b1;

        // ALU add
        issue(OP_ADD, '0, 1'b0, 64'd5, 64'd7);
        chk("add_valid", {63'b0, out_valid}, 64'd1);
        chk("add_res", out_result, 64'd12);
        chk("add_err", {63'b0, out_err}, 64'd0);
        chk("add_hold_ready", {63'b0, in_ready}, 64'd0);
        @(negedge clk);
        chk("add_ready", {63'b0, in_ready}, 64'd1);
        chk("add_drop", {63'b0, out_valid}, 64'd0);

        // Backpressure
        out_ready = 1'b0;
        issue(OP_SLT, '0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {63'b0, out_valid}, 64'd1);
            chk("bp_res", out_result, 64'd1);
            chk("bp_ready", {63'b0, in_ready}, 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {63'b0, out_valid}, 64'd0);
        chk("bp_release_ready", {63'b0, in_ready}, 64'd1);

        // ALU must not be driven when a divide is presented
        @(negedge clk);
        in_valid = 1'b1; in_alu_op = OP_ADD; in_div_op = D_DIV;
        #1 chk("div_alu_gate", {52'b0, alu_op}, 64'd0);
        in_valid = 1'b0; in_alu_op = '0; in_div_op = '0;

        // Divides
        div_case("div", D_DIV, 1'b0, -64'sd20, 64'd3, 66, -64'sd6);
        div_case("rem", D_REM, 1'b0, -64'sd20, 64'd3, 66, -64'sd2);
        div_case("divuw", D_DIVU, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'd2, 34, 64'd3);

        // Special cases
        div_case("div0", D_DIV, 1'b0, 64'd42, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        div_case("rem0", D_REM, 1'b0, 64'd42, 64'd0, 1, 64'd42);
        div_case("divw_ovf", D_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 1, 64'hFFFF_FFFF_8000_0000);
        div_case("remw_ovf", D_REM, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 1, 64'd0);

        // Flush mid-divide (cnt reaches 20 after 43 further cycles)
        seen = 1'b0;
        issue('0, D_DIV, 1'b0, 64'd100, 64'd7);
        repeat (43) begin
            seen |= out_valid;
            @(negedge clk);
        end
        chk("flush_busy_before", {63'b0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", {63'b0, busy}, 64'd0);
        chk("flush_ready", {63'b0, in_ready}, 64'd1);
        repeat (30) begin
            seen |= out_valid;
            @(negedge clk);
        end
        chk("flush_no_valid", {63'b0, seen}, 64'd0);
        issue(OP_ADD, '0, 1'b0, 64'd3, 64'd4);
        chk("flush_add_valid", {63'b0, out_valid}, 64'd1);
        chk("flush_add_res", out_result, 64'd7);
        @(negedge clk);

        // Flush beats accept in the same cycle
        in_valid = 1'b1; in_alu_op = OP_ADD; in_src1 = 64'd1; in_src2 = 64'd1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_alu_op = '0; flush = 1'b0;
        chk("flush_prio_busy", {63'b0, busy}, 64'd0);
        chk("flush_prio_valid", {63'b0, out_valid}, 64'd0);

        // Illegal op, then reset while holding
        out_ready = 1'b0;
        issue(OP_SP, '0, 1'b0, 64'd9, 64'd9);
        chk("ill_valid", {63'b0, out_valid}, 64'd1);
        chk("ill_err", {63'b0, out_err}, 64'd1);
        chk("ill_res", out_result, 64'hA5A5_5A5A_DEAD_BEEF);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_hold_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_hold_res", out_result, 64'd0);
        chk("rst_hold_err", {63'b0, out_err}, 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
